// File: rtl/rsc_control_unit.sv
// rsc_control_unit: hardwired Moore control unit for the 8-bit relatively simple CPU.
// Sequences fetch/decode/execute and drives register loads/increments, memory strobes,
// the encoded bus-driver select and the ALUS7..ALUS1 function code.
// Optional feature macro: MEM_WAIT_EN (memory states wait for MEM_READY).
// Parameter ILLEGAL_HALT: 1 = opcode with IR_OP[7:4]!=0 halts, 0 = executes as NOP.
module rsc_control_unit #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] IR_OP,
    input  logic       Z,
    input  logic       MEM_READY,
    output logic [9:0] LOADS,
    output logic [2:0] BUS_SEL,
    output logic       READ,
    output logic       WRITE,
    output logic [6:0] ALUS,
    output logic       HALTED,
    output logic [4:0] STATE
);

    // LOADS bit positions: {AR_LOAD,AR_INC,PC_LOAD,PC_INC,DR_LOAD,TR_LOAD,IR_LOAD,R_LOAD,AC_LOAD,Z_LOAD}
    localparam logic [9:0] L_AR  = 10'b10_0000_0000;
    localparam logic [9:0] L_ARI = 10'b01_0000_0000;
    localparam logic [9:0] L_PC  = 10'b00_1000_0000;
    localparam logic [9:0] L_PCI = 10'b00_0100_0000;
    localparam logic [9:0] L_DR  = 10'b00_0010_0000;
    localparam logic [9:0] L_TR  = 10'b00_0001_0000;
    localparam logic [9:0] L_IR  = 10'b00_0000_1000;
    localparam logic [9:0] L_R   = 10'b00_0000_0100;
    localparam logic [9:0] L_AC  = 10'b00_0000_0010;
    localparam logic [9:0] L_Z   = 10'b00_0000_0001;

    localparam logic [2:0] B_NONE = 3'd0;
    localparam logic [2:0] B_MEM  = 3'd1;
    localparam logic [2:0] B_PC   = 3'd2;
    localparam logic [2:0] B_DR   = 3'd3;
    localparam logic [2:0] B_DRTR = 3'd4;
    localparam logic [2:0] B_R    = 3'd5;
    localparam logic [2:0] B_AC   = 3'd6;

    localparam logic [6:0] A_PASS = 7'b0000010;
    localparam logic [6:0] A_ADD  = 7'b0000011;
    localparam logic [6:0] A_SUB  = 7'b0001101;
    localparam logic [6:0] A_INAC = 7'b0001001;
    localparam logic [6:0] A_CLAC = 7'b0000000;
    localparam logic [6:0] A_AND  = 7'b1000000;
    localparam logic [6:0] A_OR   = 7'b1010000;
    localparam logic [6:0] A_XOR  = 7'b1100000;
    localparam logic [6:0] A_NOT  = 7'b1110000;

    // ADDR3 is split by destination so its outputs stay a pure function of state.
    typedef enum logic [4:0] {
        S_RST0 = 5'd0, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ADDR1, S_ADDR2, S_ADDR3M, S_ADDR3J,
        S_LD1, S_LD2, S_ST1, S_ST2,
        S_MVAC1, S_MOVR1, S_ADD1, S_SUB1, S_INAC1, S_CLAC1,
        S_AND1, S_OR1, S_XOR1, S_NOT1,
        S_JN1, S_JN2, S_HALT
    } state_t;

    typedef struct packed {
        logic [9:0] loads;
        logic [2:0] bus;
        logic       rd;
        logic       wr;
        logic [6:0] alus;
        logic       halt;
    } ctl_t;

    state_t state;
    state_t nxt;
    ctl_t   ctl;
    logic   stall;

    function automatic ctl_t decode(input state_t s);
        ctl_t d;
        d = '0;
        case (s)
            S_FETCH1: begin d.loads = L_AR;              d.bus = B_PC;                end
            S_FETCH2: begin d.loads = L_DR | L_PCI;      d.bus = B_MEM;  d.rd = 1'b1; end
            S_FETCH3: begin d.loads = L_IR | L_AR;       d.bus = B_PC;                end
            S_ADDR1:  begin d.loads = L_DR | L_PCI | L_ARI; d.bus = B_MEM; d.rd = 1'b1; end
            S_ADDR2:  begin d.loads = L_TR | L_DR | L_PCI;  d.bus = B_MEM; d.rd = 1'b1; end
            S_ADDR3M: begin d.loads = L_AR;              d.bus = B_DRTR;              end
            S_ADDR3J: begin d.loads = L_PC;              d.bus = B_DRTR;              end
            S_LD1:    begin d.loads = L_DR;              d.bus = B_MEM;  d.rd = 1'b1; end
            S_LD2:    begin d.loads = L_AC | L_Z;        d.bus = B_DR;   d.alus = A_PASS; end
            S_ST1:    begin d.loads = L_DR;              d.bus = B_AC;                end
            S_ST2:    begin                              d.bus = B_DR;   d.wr = 1'b1; end
            S_MVAC1:  begin d.loads = L_R;               d.bus = B_AC;                end
            S_MOVR1:  begin d.loads = L_AC | L_Z;        d.bus = B_R;    d.alus = A_PASS; end
            S_ADD1:   begin d.loads = L_AC | L_Z;        d.bus = B_R;    d.alus = A_ADD;  end
            S_SUB1:   begin d.loads = L_AC | L_Z;        d.bus = B_R;    d.alus = A_SUB;  end
            S_AND1:   begin d.loads = L_AC | L_Z;        d.bus = B_R;    d.alus = A_AND;  end
            S_OR1:    begin d.loads = L_AC | L_Z;        d.bus = B_R;    d.alus = A_OR;   end
            S_XOR1:   begin d.loads = L_AC | L_Z;        d.bus = B_R;    d.alus = A_XOR;  end
            S_INAC1:  begin d.loads = L_AC | L_Z;        d.bus = B_NONE; d.alus = A_INAC; end
            S_CLAC1:  begin d.loads = L_AC | L_Z;        d.bus = B_NONE; d.alus = A_CLAC; end
            S_NOT1:   begin d.loads = L_AC | L_Z;        d.bus = B_NONE; d.alus = A_NOT;  end
            S_JN1:    begin d.loads = L_PCI;                                          end
            S_JN2:    begin d.loads = L_PCI;                                          end
            S_HALT:   begin d.halt = 1'b1;                                            end
            default:  d = '0;
        endcase
        return d;
    endfunction

    // Next-state selection from current state, opcode and zero flag
    always_comb begin
        nxt = S_FETCH1;
        case (state)
            S_RST0:   nxt = S_FETCH1;
            S_FETCH1: nxt = S_FETCH2;
            S_FETCH2: nxt = S_FETCH3;
            S_FETCH3: nxt = S_DECODE;
            S_DECODE: begin
                if (IR_OP[7:4] != 4'h0) begin
                    nxt = ILLEGAL_HALT ? S_HALT : S_FETCH1;
                end else begin
                    case (IR_OP[3:0])
                        4'h0: nxt = S_FETCH1;
                        4'h1: nxt = S_ADDR1;
                        4'h2: nxt = S_ADDR1;
                        4'h3: nxt = S_MVAC1;
                        4'h4: nxt = S_MOVR1;
                        4'h5: nxt = S_ADDR1;
                        4'h6: nxt = Z ? S_ADDR1 : S_JN1;
                        4'h7: nxt = Z ? S_JN1 : S_ADDR1;
                        4'h8: nxt = S_ADD1;
                        4'h9: nxt = S_SUB1;
                        4'hA: nxt = S_INAC1;
                        4'hB: nxt = S_CLAC1;
                        4'hC: nxt = S_AND1;
                        4'hD: nxt = S_OR1;
                        4'hE: nxt = S_XOR1;
                        default: nxt = S_NOT1;
                    endcase
                end
            end
            S_ADDR1:  nxt = S_ADDR2;
            S_ADDR2:  nxt = ((IR_OP[3:0] == 4'h1) || (IR_OP[3:0] == 4'h2)) ? S_ADDR3M : S_ADDR3J;
            S_ADDR3M: nxt = (IR_OP[3:0] == 4'h1) ? S_LD1 : S_ST1;
            S_LD1:    nxt = S_LD2;
            S_ST1:    nxt = S_ST2;
            S_JN1:    nxt = S_JN2;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_FETCH1;
        endcase
    end

`ifdef MEM_WAIT_EN
    // A memory-access state holds until the memory acknowledges
    always_comb stall = (ctl.rd | ctl.wr) & ~MEM_READY;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = MEM_READY;
    // Every state lasts exactly one cycle
    always_comb stall = 1'b0;
`endif

    // State register with outputs registered from the decode of the entered state
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_RST0;
            ctl   <= '0;
        end else if (!stall) begin
            state <= nxt;
            ctl   <= decode(nxt);
        end
    end

    // Loads and increments fire only on the cycle a memory state completes
    always_comb begin
        LOADS   = ctl.loads & ~{10{stall}};
        BUS_SEL = ctl.bus;
        READ    = ctl.rd;
        WRITE   = ctl.wr;
        ALUS    = ctl.alus;
        HALTED  = ctl.halt;
        STATE   = state;
    end

endmodule

// File: tb/tb_rsc_control_unit.sv
// tb_rsc_control_unit: randomized self-checking bench for rsc_control_unit.
// Two instances (ILLEGAL_HALT 0 and 1) share stimulus; expected per-cycle outputs come
// from a per-instruction micro-operation list built from the instruction set rules.
// Honours MEM_WAIT_EN when defined.
`timescale 1ns/1ps
module tb_rsc_control_unit;

    localparam logic [9:0] L_AR  = 10'b10_0000_0000;
    localparam logic [9:0] L_ARI = 10'b01_0000_0000;
    localparam logic [9:0] L_PC  = 10'b00_1000_0000;
    localparam logic [9:0] L_PCI = 10'b00_0100_0000;
    localparam logic [9:0] L_DR  = 10'b00_0010_0000;
    localparam logic [9:0] L_TR  = 10'b00_0001_0000;
    localparam logic [9:0] L_IR  = 10'b00_0000_1000;
    localparam logic [9:0] L_R   = 10'b00_0000_0100;
    localparam logic [9:0] L_AC  = 10'b00_0000_0010;
    localparam logic [9:0] L_Z   = 10'b00_0000_0001;
    localparam logic [9:0] L_ACZ = L_AC | L_Z;

    typedef struct packed {
        logic [9:0] loads;
        logic [2:0] bus;
        logic       rd;
        logic       wr;
        logic [6:0] alus;
        logic       halt;
    } exp_t;
    typedef exp_t seq_t[$];

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [7:0] IR_OP = 8'h00;
    logic       Z = 1'b0;
    logic       MEM_READY = 1'b1;

    logic [9:0] loads0, loads1;
    logic [2:0] bus0, bus1;
    logic       rd0, rd1, wr0, wr1, h0, h1;
    logic [6:0] alus0, alus1;
    logic [4:0] st0, st1;

    int n_checks = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    rsc_control_unit #(.ILLEGAL_HALT(1'b0)) dut0 (
        .CLK(CLK), .RESET_N(RESET_N), .IR_OP(IR_OP), .Z(Z), .MEM_READY(MEM_READY),
        .LOADS(loads0), .BUS_SEL(bus0), .READ(rd0), .WRITE(wr0), .ALUS(alus0),
        .HALTED(h0), .STATE(st0)
    );

    rsc_control_unit #(.ILLEGAL_HALT(1'b1)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .IR_OP(IR_OP), .Z(Z), .MEM_READY(MEM_READY),
        .LOADS(loads1), .BUS_SEL(bus1), .READ(rd1), .WRITE(wr1), .ALUS(alus1),
        .HALTED(h1), .STATE(st1)
    );

    function automatic exp_t mk(input logic [9:0] l, input logic [2:0] b, input logic r,
                                input logic w, input logic [6:0] a);
        exp_t e;
        e.loads = l; e.bus = b; e.rd = r; e.wr = w; e.alus = a; e.halt = 1'b0;
        return e;
    endfunction

    // Cycle-by-cycle micro-operations of one instruction, FETCH1 onward.
    // A trailing halt entry is sticky: it never leaves the queue.
    function automatic seq_t micro(input logic [7:0] op, input logic zf, input bit ih);
        seq_t s;
        exp_t hlt;
        bit   jump;
        hlt = '0; hlt.halt = 1'b1;
        s.push_back(mk(L_AR,        3'd2, 1'b0, 1'b0, 7'd0));
        s.push_back(mk(L_DR | L_PCI, 3'd1, 1'b1, 1'b0, 7'd0));
        s.push_back(mk(L_IR | L_AR, 3'd2, 1'b0, 1'b0, 7'd0));
        s.push_back(mk(10'd0,       3'd0, 1'b0, 1'b0, 7'd0));
        if (op[7:4] != 4'h0) begin
            if (ih) s.push_back(hlt);
            return s;
        end
        jump = (op[3:0] == 4'h5) || (op[3:0] == 4'h6 && zf) || (op[3:0] == 4'h7 && !zf);
        if (op[3:0] == 4'h1 || op[3:0] == 4'h2 || jump) begin
            s.push_back(mk(L_DR | L_PCI | L_ARI, 3'd1, 1'b1, 1'b0, 7'd0));
            s.push_back(mk(L_TR | L_DR | L_PCI,  3'd1, 1'b1, 1'b0, 7'd0));
            s.push_back(mk(jump ? L_PC : L_AR,   3'd4, 1'b0, 1'b0, 7'd0));
        end
        case (op[3:0])
            4'h1: begin
                s.push_back(mk(L_DR,  3'd1, 1'b1, 1'b0, 7'd0));
                s.push_back(mk(L_ACZ, 3'd3, 1'b0, 1'b0, 7'b0000010));
            end
            4'h2: begin
                s.push_back(mk(L_DR,  3'd6, 1'b0, 1'b0, 7'd0));
                s.push_back(mk(10'd0, 3'd3, 1'b0, 1'b1, 7'd0));
            end
            4'h3: s.push_back(mk(L_R,   3'd6, 1'b0, 1'b0, 7'd0));
            4'h4: s.push_back(mk(L_ACZ, 3'd5, 1'b0, 1'b0, 7'b0000010));
            4'h6, 4'h7: if (!jump) begin
                s.push_back(mk(L_PCI, 3'd0, 1'b0, 1'b0, 7'd0));
                s.push_back(mk(L_PCI, 3'd0, 1'b0, 1'b0, 7'd0));
            end
            4'h8: s.push_back(mk(L_ACZ, 3'd5, 1'b0, 1'b0, 7'b0000011));
            4'h9: s.push_back(mk(L_ACZ, 3'd5, 1'b0, 1'b0, 7'b0001101));
            4'hA: s.push_back(mk(L_ACZ, 3'd0, 1'b0, 1'b0, 7'b0001001));
            4'hB: s.push_back(mk(L_ACZ, 3'd0, 1'b0, 1'b0, 7'b0000000));
            4'hC: s.push_back(mk(L_ACZ, 3'd5, 1'b0, 1'b0, 7'b1000000));
            4'hD: s.push_back(mk(L_ACZ, 3'd5, 1'b0, 1'b0, 7'b1010000));
            4'hE: s.push_back(mk(L_ACZ, 3'd5, 1'b0, 1'b0, 7'b1100000));
            4'hF: s.push_back(mk(L_ACZ, 3'd0, 1'b0, 1'b0, 7'b1110000));
            default: ;
        endcase
        return s;
    endfunction

    // Expected outputs of a queue head given whether memory is stalling this cycle
    function automatic exp_t effective(input exp_t e, input bit stall);
        exp_t r;
        r = e;
        if ((e.rd || e.wr) && stall) r.loads = '0;
        return r;
    endfunction

    function automatic bit advances(input exp_t e, input bit stall);
        return !(e.halt || ((e.rd || e.wr) && stall));
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Directed program: opcode, Z, reset cycle within instruction (-1 none), FETCH2 stall
    localparam int NDIR = 12;
    logic [7:0] d_op [NDIR] = '{8'h08, 8'h06, 8'h06, 8'h02, 8'h40, 8'h00,
                                8'h03, 8'h05, 8'h07, 8'h07, 8'h0A, 8'h01};
    logic       d_z  [NDIR] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int         d_rst[NDIR] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, 7};
    bit         d_stl[NDIR] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    exp_t q0[$];
    exp_t q1[$];

    initial begin
        seq_t s;
        exp_t a0, a1, zero;
        int   dptr, idx, rst_at;
        bit   stl_f2, stall, do_rst;
        logic [7:0] op;
        logic zf;
        zero = '0;
        dptr = 0; idx = 0; rst_at = -1; stl_f2 = 1'b0;

        // Pin the model against hand-derived cycle counts and key micro-ops
        s = micro(8'h00, 1'b0, 1'b0); check_int("len_nop", s.size(), 4);
        s = micro(8'h03, 1'b0, 1'b0); check_int("len_mvac", s.size(), 5);
        s = micro(8'h06, 1'b0, 1'b0); check_int("len_jmpz_nt", s.size(), 6);
        s = micro(8'h06, 1'b1, 1'b0); check_int("len_jmpz_t", s.size(), 7);
        check_int("jmpz_t_pcload", int'(s[6].loads), int'(L_PC));
        check_int("jmpz_t_bus", int'(s[6].bus), 4);
        s = micro(8'h02, 1'b0, 1'b0); check_int("len_stac", s.size(), 9);
        check_int("st2_write", int'({s[8].wr, s[8].rd, s[8].bus}), 'b10_011);
        s = micro(8'h08, 1'b0, 1'b0);
        check_int("add_exec", int'({s[4].bus, s[4].alus, s[4].loads}),
                  int'({3'd5, 7'b0000011, L_ACZ}));
        s = micro(8'h40, 1'b0, 1'b1); check_int("illegal_halt_entry", int'(s[4].halt), 1);

        // Power-on reset: outputs zero before any clock edge
        #2;
        a0 = {loads0, bus0, rd0, wr0, alus0, h0};
        a1 = {loads1, bus1, rd1, wr1, alus1, h1};
        check("por_dut0", a0, zero);
        check("por_dut1", a1, zero);
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge CLK);
            #1;
            if (dptr >= NDIR && q0.size() != 0)
                do_rst = ($urandom_range(0, 59) == 0);
            else
                do_rst = (rst_at >= 0 && idx == rst_at);
            if (do_rst) begin
                RESET_N = 1'b0;
                #1;
                a0 = {loads0, bus0, rd0, wr0, alus0, h0};
                a1 = {loads1, bus1, rd1, wr1, alus1, h1};
                check("async_reset_dut0", a0, zero);
                check("async_reset_dut1", a1, zero);
                q0.delete();
                q1.delete();
                rst_at = -1;
                @(negedge CLK);
                RESET_N = 1'b1;
                continue;
            end
            if (q0.size() == 0) begin
                if (dptr < NDIR) begin
                    op = d_op[dptr]; zf = d_z[dptr];
                    rst_at = d_rst[dptr]; stl_f2 = d_stl[dptr];
                    dptr++;
                end else begin
                    if ($urandom_range(0, 4) == 0)
                        op = {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))};
                    else
                        op = {4'h0, 4'($urandom_range(0, 15))};
                    zf = 1'($urandom_range(0, 1));
                    rst_at = -1; stl_f2 = 1'b0;
                end
                q0 = micro(op, zf, 1'b0);
                if (q1.size() == 0) q1 = micro(op, zf, 1'b1);
                IR_OP = op;
                Z = zf;
                idx = 0;
            end
            if (dptr >= NDIR && rst_at < 0 && !stl_f2)
                MEM_READY = ($urandom_range(0, 2) != 0);
            else
                MEM_READY = !(stl_f2 && idx >= 1 && idx <= 3);
            @(negedge CLK);
            stall = 1'b0;
`ifdef MEM_WAIT_EN
            stall = !MEM_READY;
`endif
            a0 = {loads0, bus0, rd0, wr0, alus0, h0};
            a1 = {loads1, bus1, rd1, wr1, alus1, h1};
            check("cycle_dut0", a0, effective(q0[0], stall));
            check("cycle_dut1", a1, effective(q1[0], stall));
            check_int("rd_wr_excl", int'(rd0 & wr0) + int'(rd1 & wr1), 0);
            if (advances(q0[0], stall)) void'(q0.pop_front());
            if (advances(q1[0], stall)) void'(q1.pop_front());
            idx++;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
